// File: rtl/carry_select_adder_pipelined.sv
// Pipelined carry-select adder: each stage resolves BLKS_PER_STAGE slices of BLK bits.
// Define CSA_OVERFLOW_EN to build the registered signed-overflow output; otherwise ovf is tied 0.
module carry_select_adder_pipelined #(
    parameter int WIDTH          = 16,
    parameter int BLK            = 4,
    parameter int BLKS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf
);
    localparam int SPS    = BLK * BLKS_PER_STAGE;
    localparam int STAGES = WIDTH / SPS;

    logic [STAGES-1:0] vld_d, vld_q;
    logic              stall;
    logic              adv;

    // Both candidate sums are formed up front; the late-arriving carry only drives the mux.
    function automatic logic [BLK:0] csel(input logic [BLK-1:0] x, input logic [BLK-1:0] y,
                                          input logic sel);
        logic [BLK:0] r0;
        logic [BLK:0] r1;
        r0 = {1'b0, x} + {1'b0, y};
        r1 = {1'b0, x} + {1'b0, y} + {{BLK{1'b0}}, 1'b1};
        return sel ? r1 : r0;
    endfunction

    assign stall     = vld_q[STAGES-1] && !out_ready;
    assign adv       = !stall;
    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   vld_q <= '0;
        else if (adv) vld_q <= vld_d;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = WIDTH - k * SPS;  // operand bits still unresolved entering stage k
        localparam int RS = (k + 1) * SPS;    // sum bits resolved after stage k

        logic [IW-1:0]  op_a, op_b;
        logic           cy_in;
        logic [SPS-1:0] part;
        logic [RS-1:0]  sum_d, sum_q;
        logic           cy_d, cy_q;

        if (k == 0) begin : g_src
            assign op_a  = a;
            assign op_b  = b;
            assign cy_in = c_in;
            assign sum_d = part;
        end else begin : g_src
            assign op_a  = g_stage[k-1].g_ops.a_q;
            assign op_b  = g_stage[k-1].g_ops.b_q;
            assign cy_in = g_stage[k-1].cy_q;
            assign sum_d = {part, g_stage[k-1].sum_q};
        end

        always_comb begin
            logic         cy;
            logic [BLK:0] r;
            cy   = cy_in;
            r    = '0;
            part = '0;
            for (int j = 0; j < BLKS_PER_STAGE; j++) begin
                r = csel(op_a[j*BLK +: BLK], op_b[j*BLK +: BLK], cy);
                part[j*BLK +: BLK] = r[BLK-1:0];
                cy = r[BLK];
            end
            cy_d = cy;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
                cy_q  <= 1'b0;
            end else if (adv) begin
                sum_q <= sum_d;
                cy_q  <= cy_d;
            end
        end

        // Only the not-yet-added upper operand bits travel on to later stages.
        if (k < STAGES - 1) begin : g_ops
            logic [IW-SPS-1:0] a_d, b_d, a_q, b_q;
            assign a_d = op_a[IW-1:SPS];
            assign b_d = op_b[IW-1:SPS];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    assign s = g_stage[STAGES-1].sum_q;
    assign c = g_stage[STAGES-1].cy_q;

`ifdef CSA_OVERFLOW_EN
    logic ovf_d, ovf_q;
    // a^b^s at the MSB recovers the carry into the MSB.
    assign ovf_d = g_stage[STAGES-1].cy_d ^ g_stage[STAGES-1].op_a[SPS-1]
                 ^ g_stage[STAGES-1].op_b[SPS-1] ^ g_stage[STAGES-1].part[SPS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ovf_q <= 1'b0;
        else if (adv) ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
